// File: rtl/fog_acc_pkg.sv
// Shared FSM encodings and default widths for the FOG rate accumulate-and-dump stage
// and the output/packet stage that consumes it.
package fog_acc_pkg;

  localparam int FOG_DATA_W = 32;
  localparam int FOG_CNT_W  = 16;
  localparam int FOG_ACC_W  = 48;
  localparam int FOG_OUT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2
  } fog_state_e;

endpackage

// File: rtl/fog_sat_shift.sv
// Two-stage scaler: arithmetic right shift (rounded half up when FOG_ACC_ROUND_EN is
// defined, truncating otherwise), then saturation to OUT_W with held registered outputs.
module fog_sat_shift
  import fog_acc_pkg::*;
#(
  parameter int ACC_W = FOG_ACC_W,
  parameter int CNT_W = FOG_CNT_W,
  parameter int OUT_W = FOG_OUT_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic [5:0]              i_shift,
  input  logic [CNT_W-1:0]        i_cnt,
  input  logic                    i_ovf,
  output logic signed [OUT_W-1:0] o_rate,
  output logic                    o_valid,
  output logic [CNT_W-1:0]        o_cnt,
  output logic                    o_sat,
  output logic                    o_ovf
);

  // Full-scale limits expressed in the ACC_W+1 working width.
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_ext;
  logic signed [ACC_W:0] pre_shift;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] s1_val;
  logic                  s1_valid;
  logic [CNT_W-1:0]      s1_cnt;
  logic                  s1_ovf;

  assign sum_ext = (ACC_W+1)'(i_sum);

`ifdef FOG_ACC_ROUND_EN
  logic signed [ACC_W:0] half_lsb;
  // The extra bit of headroom keeps the rounding add from wrapping.
  assign half_lsb  = (i_shift == 6'd0) ? '0 : ((ACC_W+1)'(1) << (i_shift - 6'd1));
  assign pre_shift = sum_ext + half_lsb;
`else
  assign pre_shift = sum_ext;
`endif

  assign shifted = pre_shift >>> i_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_cnt   <= '0;
      s1_ovf   <= 1'b0;
      o_valid  <= 1'b0;
      o_rate   <= '0;
      o_cnt    <= '0;
      o_sat    <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_val <= shifted;
        s1_cnt <= i_cnt;
        s1_ovf <= i_ovf;
      end
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_cnt <= s1_cnt;
        o_ovf <= s1_ovf;
        if (s1_val > SAT_MAX) begin
          o_rate <= SAT_MAX[OUT_W-1:0];
          o_sat  <= 1'b1;
        end else if (s1_val < SAT_MIN) begin
          o_rate <= SAT_MIN[OUT_W-1:0];
          o_sat  <= 1'b1;
        end else begin
          o_rate <= s1_val[OUT_W-1:0];
          o_sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fog_rate_accum_dump.sv
// Accumulate-and-dump of the Kalman rate estimate over count- or sync-bounded windows.
// Optional rounding before the scaling shift is enabled by defining FOG_ACC_ROUND_EN.
module fog_rate_accum_dump
  import fog_acc_pkg::*;
#(
  parameter int DATA_W = FOG_DATA_W,
  parameter int CNT_W  = FOG_CNT_W,
  parameter int ACC_W  = FOG_ACC_W,
  parameter int OUT_W  = FOG_OUT_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic [CNT_W-1:0]         i_win_len,
  input  logic [5:0]               i_shift,
  input  logic                     i_sync_mode,
  input  logic                     i_sync,
  output logic signed [OUT_W-1:0]  o_rate,
  output logic                     o_valid,
  output logic [CNT_W-1:0]         o_cnt,
  output logic                     o_sat,
  output logic                     o_ovf,
  output fog_state_e               o_state
);

  // Output handshake: o_valid is a one-cycle strobe with no ready; the consumer must
  // take o_rate/o_cnt/o_sat/o_ovf on that cycle, and they hold until the next strobe.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fog_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, x_ext, sum_inc, snap_sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc, snap_cnt, len_q, len_eff;
  logic [5:0]              shift_q;
  logic                    mode_q, latch, close, snap_ovf;

  assign x_ext   = ACC_W'(i_x);
  assign sum_inc = acc_q + x_ext;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign len_eff = (len_q == '0) ? CNT_W'(1) : len_q;
  assign o_state = state_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    close    = 1'b0;
    snap_sum = sum_inc;
    snap_cnt = cnt_inc;
    snap_ovf = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          latch   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = i_sync_mode ? ARM : ACCUM;
        end
        ARM: begin
          if (i_sync) begin
            latch   = 1'b1;
            acc_d   = x_ext;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (!mode_q) begin
            // Count mode: the closing sample is inside the published sum.
            if (cnt_inc == len_eff) begin
              close = 1'b1;
              latch = 1'b1;
              acc_d = '0;
              cnt_d = '0;
            end else begin
              acc_d = sum_inc;
              cnt_d = cnt_inc;
            end
          end else if (i_sync) begin
            // Sync sample opens the new window; an empty window (right after a
            // forced close or a mode switch) is not published.
            close    = (cnt_q != '0);
            snap_sum = acc_q;
            snap_cnt = cnt_q;
            latch    = 1'b1;
            acc_d    = x_ext;
            cnt_d    = CNT_W'(1);
          end else if (cnt_inc == CNT_MAX) begin
            close    = 1'b1;
            snap_ovf = 1'b1;
            latch    = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            acc_d = sum_inc;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        len_q   <= i_win_len;
        mode_q  <= i_sync_mode;
        shift_q <= i_shift;
      end
    end
  end

  fog_sat_shift #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W),
    .OUT_W(OUT_W)
  ) u_sat_shift (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(close),
    .i_sum  (snap_sum),
    .i_shift(shift_q),
    .i_cnt  (snap_cnt),
    .i_ovf  (snap_ovf),
    .o_rate (o_rate),
    .o_valid(o_valid),
    .o_cnt  (o_cnt),
    .o_sat  (o_sat),
    .o_ovf  (o_ovf)
  );

endmodule

// File: tb/tb_fog_rate_accum_dump.sv
// Directed bench for fog_rate_accum_dump: default build, a 16-bit output build and a
// 4-bit counter build share one stimulus stream.
module tb_fog_rate_accum_dump;
  import fog_acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sync_mode = 1'b0;
  logic sync = 1'b0;
  logic [31:0] x = '0;
  logic [15:0] win_len = '0;
  logic [5:0]  shift = '0;

  logic [31:0] a_rate;  logic a_valid;  logic [15:0] a_cnt;  logic a_sat;  logic a_ovf;
  logic [15:0] b_rate;  logic b_valid;  logic [15:0] b_cnt;  logic b_sat;  logic b_ovf;
  logic [31:0] c_rate;  logic c_valid;  logic [3:0]  c_cnt;  logic c_sat;  logic c_ovf;
  fog_state_e a_state, b_state, c_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  fog_rate_accum_dump u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_win_len(win_len), .i_shift(shift),
    .i_sync_mode(sync_mode), .i_sync(sync), .o_rate(a_rate), .o_valid(a_valid),
    .o_cnt(a_cnt), .o_sat(a_sat), .o_ovf(a_ovf), .o_state(a_state)
  );

  fog_rate_accum_dump #(.OUT_W(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_win_len(win_len), .i_shift(shift),
    .i_sync_mode(sync_mode), .i_sync(sync), .o_rate(b_rate), .o_valid(b_valid),
    .o_cnt(b_cnt), .o_sat(b_sat), .o_ovf(b_ovf), .o_state(b_state)
  );

  fog_rate_accum_dump #(.CNT_W(4)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_win_len(win_len[3:0]), .i_shift(shift),
    .i_sync_mode(sync_mode), .i_sync(sync), .o_rate(c_rate), .o_valid(c_valid),
    .o_cnt(c_cnt), .o_sat(c_sat), .o_ovf(c_ovf), .o_state(c_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic vsel(input int inst);
    case (inst)
      0:       return a_valid;
      1:       return b_valid;
      default: return c_valid;
    endcase
  endfunction

  task automatic strobe_after(input string tag, input int inst, input int n_quiet);
    for (int i = 0; i <= n_quiet; i++) begin
      tick();
      chk(tag, 64'(vsel(inst)), 64'(i == n_quiet));
    end
  endtask

  // scoreboard: expected a_rate values in publish order
  task automatic sb_check(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tag, 64'(a_rate), 64'(e));
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_rate",  64'(a_rate),  64'd0);
    chk("rst_cnt",   64'(a_cnt),   64'd0);
    chk("rst_sat",   64'(a_sat),   64'd0);
    chk("rst_ovf",   64'(a_ovf),   64'd0);
    chk("rst_state", 64'(a_state), 64'(IDLE));
    rst = 1'b0;

    // 1: count mode, 4-sample windows of 100, shift 2
    win_len = 16'd4; shift = 6'd2; x = 32'd100; sync_mode = 1'b0; en = 1'b1;
    tick();
    chk("t1_state", 64'(a_state), 64'(ACCUM));
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd100);
    strobe_after("t1_strobe1", 0, 4);
    sb_check("t1_rate1");
    chk("t1_cnt", 64'(a_cnt), 64'd4);
    chk("t1_sat", 64'(a_sat), 64'd0);
    strobe_after("t1_strobe2", 0, 3);
    sb_check("t1_rate2");
    en = 1'b0;
    tick(); tick();
    chk("t1_idle", 64'(a_state), 64'(IDLE));
    chk("t1_hold_rate", 64'(a_rate), 64'd100);

    // 2: 5+6+6 = 17 shifted by 1
    win_len = 16'd3; shift = 6'd1; x = 32'd0; en = 1'b1;
    tick();
    x = 32'd5; tick(); chk("t2_quiet", 64'(a_valid), 64'd0);
    x = 32'd6; tick(); chk("t2_quiet", 64'(a_valid), 64'd0);
    x = 32'd6; tick(); chk("t2_quiet", 64'(a_valid), 64'd0);
    x = 32'd0; tick(); chk("t2_strobe", 64'(a_valid), 64'd1);
`ifdef FOG_ACC_ROUND_EN
    exp_q.push_back(32'd9);
`else
    exp_q.push_back(32'd8);
`endif
    sb_check("t2_rate");
    chk("t2_cnt", 64'(a_cnt), 64'd3);
    en = 1'b0;
    tick(); tick();

    // 3: sync mode, syncs at cycles 10 and 20, window = samples 10..19
    shift = 6'd0; sync_mode = 1'b1; x = 32'd0; en = 1'b1;
    tick();
    chk("t3_arm", 64'(a_state), 64'(ARM));
    for (int k = 1; k <= 9; k++) begin
      x = 32'(k); tick(); chk("t3_quiet_arm", 64'(a_valid), 64'd0);
    end
    x = 32'd10; sync = 1'b1; tick(); sync = 1'b0;
    chk("t3_accum", 64'(a_state), 64'(ACCUM));
    for (int k = 11; k <= 19; k++) begin
      x = 32'(k); tick(); chk("t3_quiet_win", 64'(a_valid), 64'd0);
    end
    x = 32'd20; sync = 1'b1; tick(); sync = 1'b0;
    chk("t3_quiet_close", 64'(a_valid), 64'd0);
    x = 32'd21; tick();
    chk("t3_strobe", 64'(a_valid), 64'd1);
    exp_q.push_back(32'd145);
    sb_check("t3_rate");
    chk("t3_cnt", 64'(a_cnt), 64'd10);
    chk("t3_ovf", 64'(a_ovf), 64'd0);
    tick();
    chk("t3_one_cycle", 64'(a_valid), 64'd0);
    en = 1'b0;
    tick(); tick();

    // 4: saturation on the 16-bit output build
    sync_mode = 1'b0; shift = 6'd0; win_len = 16'd2; x = 32'd20000; en = 1'b1;
    tick();
    strobe_after("t4_pos_strobe", 1, 2);
    chk("t4_pos_rate", 64'(b_rate), 64'h7FFF);
    chk("t4_pos_sat",  64'(b_sat),  64'd1);
    chk("t4_pos_cnt",  64'(b_cnt),  64'd2);
    chk("t4_wide_rate", 64'(a_rate), 64'd40000);
    chk("t4_wide_sat",  64'(a_sat),  64'd0);
    en = 1'b0;
    tick(); tick();
    x = 32'hFFFF_B1E0; en = 1'b1;
    tick();
    strobe_after("t4_neg_strobe", 1, 2);
    chk("t4_neg_rate", 64'(b_rate), 64'h8000);
    chk("t4_neg_sat",  64'(b_sat),  64'd1);
    chk("t4_wide_neg", 64'(a_rate), 64'hFFFF_63C0);
    en = 1'b0;
    tick(); tick();

    // 5: abort by enable, clean restart, then reset mid-window
    win_len = 16'd4; shift = 6'd0; x = 32'd7; en = 1'b1;
    tick();
    tick(); tick();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t5_abort_quiet", 64'(a_valid), 64'd0);
    end
    chk("t5_abort_idle", 64'(a_state), 64'(IDLE));
    en = 1'b1; x = 32'd3;
    tick();
    strobe_after("t5_clean_strobe", 0, 4);
    exp_q.push_back(32'd12);
    sb_check("t5_clean_rate");
    chk("t5_clean_cnt", 64'(a_cnt), 64'd4);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_rate",  64'(a_rate),  64'd0);
    chk("t5_rst_cnt",   64'(a_cnt),   64'd0);
    chk("t5_rst_valid", 64'(a_valid), 64'd0);
    chk("t5_rst_state", 64'(a_state), 64'(IDLE));
    rst = 1'b0; en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t5_rst_quiet", 64'(a_valid), 64'd0);
    end

    // 6: forced close at count 15 on the 4-bit counter build
    sync_mode = 1'b1; shift = 6'd0; x = 32'd1; sync = 1'b0; en = 1'b1;
    tick();
    sync = 1'b1; tick(); sync = 1'b0;
    strobe_after("t6_force_strobe", 2, 14);
    chk("t6_force_cnt",  64'(c_cnt),  64'd15);
    chk("t6_force_ovf",  64'(c_ovf),  64'd1);
    chk("t6_force_rate", 64'(c_rate), 64'd15);
    for (int k = 0; k < 5; k++) begin
      tick(); chk("t6_quiet", 64'(c_valid), 64'd0);
    end
    sync = 1'b1; tick(); sync = 1'b0;
    chk("t6_quiet_close", 64'(c_valid), 64'd0);
    tick();
    chk("t6_next_strobe", 64'(c_valid), 64'd1);
    chk("t6_next_cnt",  64'(c_cnt),  64'd6);
    chk("t6_next_ovf",  64'(c_ovf),  64'd0);
    chk("t6_next_rate", 64'(c_rate), 64'd6);
    en = 1'b0;
    tick(); tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
